// File: rtl/wash_state_controller.sv
// wash_state_controller: washing machine mode FSM and preset selector; define WASH_DOOR_LOCK_EN for door_lock output and door-open fault in RUN
module wash_state_controller #(
  parameter int ARM_DELAY = 16,
  parameter int ARM_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        power_btn,
  input  logic        start_btn,
  input  logic        mode_btn,
  input  logic        door_open,
  input  logic        fault,
  input  logic        hadFinish,
  input  logic [2:0]  initTime,
  input  logic [2:0]  finishTime,
  output logic [2:0]  state,
  output logic [25:0] data,
  output logic [1:0]  prog,
`ifdef WASH_DOOR_LOCK_EN
  output logic        door_lock,
`endif
  output logic        beep
);
  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_BEGIN = 3'd1,
    S_SET   = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4,
    S_PAUSE = 3'd5,
    S_FIN   = 3'd6
  } state_t;
  state_t st, nxt;
  logic [ARM_W-1:0] arm;
  logic armed, beep_n;
  logic [1:0] prog_n;
  function automatic logic [25:0] preset(input logic [1:0] p);
    return p == 2'd0 ? {3'd2, 4'd9, 3'd3, 3'd2, 3'd3, 4'd6, 3'd2, 3'd0} :
           p == 2'd1 ? {3'd0, 4'd4, 3'd2, 3'd1, 3'd0, 4'd3, 3'd1, 3'd0} :
           p == 2'd2 ? {3'd5, 4'd15, 3'd4, 3'd3, 3'd4, 4'd12, 3'd3, 3'd2} :
                       {3'd0, 4'd0, 3'd0, 3'd0, 3'd0, 4'd8, 3'd2, 3'd0};
  endfunction
  assign state = st;
  always_comb begin
    armed = arm == ARM_W'(ARM_DELAY);
    nxt = st;
    prog_n = prog;
    beep_n = 1'b0;
    if (st == S_OFF) nxt = power_btn ? S_BEGIN : S_OFF;
    else if (power_btn) nxt = S_OFF;
    else if (fault && (st inside {S_BEGIN, S_SET, S_RUN, S_PAUSE, S_FIN})) begin
      nxt = S_ERR;
      beep_n = 1'b1;
    end else begin
      case (st)
        S_BEGIN: nxt = armed && initTime == 3'd0 ? S_SET : S_BEGIN;
        S_SET: begin
          nxt = start_btn && !door_open ? S_RUN : S_SET;
          beep_n = start_btn && door_open;
          prog_n = mode_btn && !start_btn ? prog + 2'd1 : prog;
        end
        S_RUN: begin
          if (armed && hadFinish) begin
            nxt = S_FIN;
            beep_n = 1'b1;
          end else if (start_btn) nxt = S_PAUSE;
          else if (door_open) begin
`ifdef WASH_DOOR_LOCK_EN
            nxt = S_ERR;
            beep_n = 1'b1;
`else
            nxt = S_PAUSE;
`endif
          end
        end
        S_PAUSE: begin
          nxt = start_btn && !door_open ? S_RUN : S_PAUSE;
          beep_n = start_btn && door_open;
        end
        S_ERR: nxt = start_btn && !fault ? S_SET : S_ERR;
        S_FIN: nxt = armed && finishTime == 3'd0 ? S_OFF : S_FIN;
        default: nxt = S_OFF;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= S_OFF;
      prog <= 2'd0;
      data <= preset(2'd0);
      beep <= 1'b0;
      arm <= '0;
`ifdef WASH_DOOR_LOCK_EN
      door_lock <= 1'b0;
`endif
    end else begin
      st <= nxt;
      prog <= prog_n;
      data <= preset(prog);
      beep <= beep_n;
      arm <= nxt != st ? '0 : armed ? arm : arm + 1'b1;
`ifdef WASH_DOOR_LOCK_EN
      door_lock <= nxt == S_RUN;
`endif
    end
  end
endmodule

// File: tb/tb_wash_state_controller.sv
// tb_wash_state_controller: scoreboard bench, stimulus queues expected outputs per cycle, monitor compares
module tb_wash_state_controller;
  localparam logic [2:0] OFF = 3'd0, BEG = 3'd1, SET = 3'd2, RUN = 3'd3, ERR = 3'd4, PAU = 3'd5, FIN = 3'd6;
  logic clk = 1'b0, rst_n = 1'b0;
  logic power_btn = 1'b0, start_btn = 1'b0, mode_btn = 1'b0, door_open = 1'b0, fault = 1'b0, hadFinish = 1'b0;
  logic [2:0] initTime = 3'd0, finishTime = 3'd0;
  logic [2:0] state;
  logic [25:0] data;
  logic [1:0] prog;
  logic beep;
`ifdef WASH_DOOR_LOCK_EN
  logic door_lock;
`endif
  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0] tag;
    logic [2:0] st;
    logic [1:0] prg;
    logic [25:0] dat;
    logic bp;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  wash_state_controller dut (
    .clk(clk), .rst_n(rst_n), .power_btn(power_btn), .start_btn(start_btn), .mode_btn(mode_btn),
    .door_open(door_open), .fault(fault), .hadFinish(hadFinish), .initTime(initTime), .finishTime(finishTime),
    .state(state), .data(data), .prog(prog),
`ifdef WASH_DOOR_LOCK_EN
    .door_lock(door_lock),
`endif
    .beep(beep)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [25:0] tbl(input logic [1:0] p);
    case (p)
      2'd0: tbl = {3'd2, 4'd9, 3'd3, 3'd2, 3'd3, 4'd6, 3'd2, 3'd0};
      2'd1: tbl = {3'd0, 4'd4, 3'd2, 3'd1, 3'd0, 4'd3, 3'd1, 3'd0};
      2'd2: tbl = {3'd5, 4'd15, 3'd4, 3'd3, 3'd4, 4'd12, 3'd3, 3'd2};
      default: tbl = {3'd0, 4'd0, 3'd0, 3'd0, 3'd0, 4'd8, 3'd2, 3'd0};
    endcase
  endfunction
  always @(negedge clk) begin : mon
    exp_t e;
    logic lk_bad;
    while (q.size() > 0 && q[0].cyc == 32'(cyc)) begin
      e = q.pop_front();
      checks++;
`ifdef WASH_DOOR_LOCK_EN
      lk_bad = door_lock !== (e.st == RUN);
`else
      lk_bad = 1'b0;
`endif
      if (state !== e.st || prog !== e.prg || data !== e.dat || beep !== e.bp || lk_bad) begin
        errors++;
        $display("FAIL step%0d cyc%0d: got state=%0d prog=%0d data=%h beep=%b lock_bad=%b, want state=%0d prog=%0d data=%h beep=%b",
                 e.tag, cyc, state, prog, data, beep, lk_bad, e.st, e.prg, e.dat, e.bp);
      end
    end
  end
  task automatic step(input logic [7:0] tag, input logic [2:0] s, input logic [1:0] p, input logic [1:0] pd, input logic bp);
    exp_t e;
    e.cyc = 32'(cyc + 1);
    e.tag = tag;
    e.st = s;
    e.prg = p;
    e.dat = tbl(pd);
    e.bp = bp;
    q.push_back(e);
    @(posedge clk);
    #1;
    power_btn = 1'b0;
    start_btn = 1'b0;
    mode_btn = 1'b0;
  endtask
  initial begin
    @(posedge clk);
    #1;
    step(1, OFF, 0, 0, 0);
    rst_n = 1'b1;
    step(2, OFF, 0, 0, 0);
    start_btn = 1; mode_btn = 1; fault = 1;
    step(3, OFF, 0, 0, 0);
    fault = 0; power_btn = 1; initTime = 3'd5;
    step(4, BEG, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(5, BEG, 0, 0, 0);
    initTime = 3'd0;
    step(6, SET, 0, 0, 0);
    mode_btn = 1; step(7, SET, 1, 0, 0);
    mode_btn = 1; step(8, SET, 2, 1, 0);
    mode_btn = 1; step(9, SET, 3, 2, 0);
    mode_btn = 1; step(10, SET, 0, 3, 0);
    mode_btn = 1; step(11, SET, 1, 0, 0);
    step(12, SET, 1, 1, 0);
    door_open = 1; start_btn = 1;
    step(13, SET, 1, 1, 1);
    step(14, SET, 1, 1, 0);
    door_open = 0; mode_btn = 1; start_btn = 1;
    step(15, RUN, 1, 1, 0);
    door_open = 1;
`ifdef WASH_DOOR_LOCK_EN
    step(16, ERR, 1, 1, 1);
    door_open = 0; start_btn = 1;
    step(17, SET, 1, 1, 0);
`else
    step(16, PAU, 1, 1, 0);
    start_btn = 1;
    step(17, PAU, 1, 1, 1);
    step(20, PAU, 1, 1, 0);
    door_open = 0;
`endif
    start_btn = 1;
    step(18, RUN, 1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      hadFinish = 1;
      step(21, RUN, 1, 1, 0);
    end
    hadFinish = 0;
    step(22, RUN, 1, 1, 0);
    step(22, RUN, 1, 1, 0);
    hadFinish = 1; start_btn = 1;
    step(23, FIN, 1, 1, 1);
    hadFinish = 0;
    for (int i = 0; i < 16; i++) step(24, FIN, 1, 1, 0);
    step(25, OFF, 1, 1, 0);
    power_btn = 1;
    step(26, BEG, 1, 1, 0);
    for (int i = 0; i < 16; i++) step(27, BEG, 1, 1, 0);
    step(28, SET, 1, 1, 0);
    mode_btn = 1; step(29, SET, 2, 1, 0);
    step(30, SET, 2, 2, 0);
    start_btn = 1; step(31, RUN, 2, 2, 0);
    fault = 1; start_btn = 1;
    step(32, ERR, 2, 2, 1);
    start_btn = 1; step(33, ERR, 2, 2, 0);
    fault = 0; start_btn = 1;
    step(34, SET, 2, 2, 0);
    start_btn = 1; step(35, RUN, 2, 2, 0);
    rst_n = 0;
    step(36, OFF, 0, 0, 0);
    rst_n = 1; power_btn = 1;
    step(37, BEG, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(38, BEG, 0, 0, 0);
    step(39, SET, 0, 0, 0);
    fault = 1; power_btn = 1;
    step(40, OFF, 0, 0, 0);
    step(41, OFF, 0, 0, 0);
    fault = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wash_state_controller.md
Name: wash_state_controller

Overview:
- Top-level mode controller for the washing machine.
- Drives the 3-bit `state` code and the 26-bit packed program-duration word consumed by the run/countdown block.
- Consumes that block's `hadFinish`, `initTime` and `finishTime` status.
- Arbitrates user buttons, door and fault inputs into state transitions, and selects one of four preset programs.

Parameters:
- ARM_DELAY, 16, clk cycles after any state change during which `hadFinish`/`initTime`/`finishTime` are ignored. Must exceed one slow-tick period (10 clk) so stale status is flushed.
- ARM_W, 5, width of the arm counter. Must satisfy 2^ARM_W > ARM_DELAY.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- power_btn  in  1  one-cycle debounced pulse
- start_btn  in  1  one-cycle pulse; start/pause/resume/clear
- mode_btn  in  1  one-cycle pulse; advance program
- door_open  in  1  level; 1 = door open
- fault  in  1  level; 1 = machine fault
- hadFinish  in  1  countdown exhausted, from run block
- initTime  in  3  power-on countdown, from run block
- finishTime  in  3  finish countdown, from run block
- state  out  3  0 shutDown, 1 begin, 2 set, 3 run, 4 error, 5 pause, 6 finish
- data  out  26  packed durations: [25:23] soak, [22:19] wash, [18:16] rinse1, [15:13] drain1, [12:10] rinse2, [9:6] spin, [5:3] drain2, [2:0] dry
- program  out  2  selected preset
- beep  out  1  one-cycle pulse

Behaviour:
- Clock and reset:
  - All outputs are registered on posedge clk.
  - rst_n=0 sampled at a clk edge: state=0, program=0, data=preset(0), beep=0, arm counter=0.
  - Reset mid-run aborts immediately; no sequencing.
- Arm counter:
  - Cleared on every cycle in which state changes.
  - Increments, saturating at ARM_DELAY.
  - "armed" means counter==ARM_DELAY.
- Presets (fields listed high to low):
  - 0 standard: 2,9,3,2,3,6,2,0
  - 1 quick: 0,4,2,1,0,3,1,0
  - 2 heavy: 5,15,4,3,4,12,3,2
  - 3 spin: 0,0,0,0,0,8,2,0
- data behaviour:
  - data = preset(program), updated the cycle after program changes.
  - Outside SET, data and program are frozen.
- Global transition priority: power_btn > fault > state-local events. At most one transition per cycle.
- power_btn in any state other than SHUTDOWN -> SHUTDOWN.
- fault=1 in BEGIN/SET/RUN/PAUSE/FINISH -> ERROR, with beep.
- SHUTDOWN: power_btn -> BEGIN. All other inputs are ignored.
- BEGIN: armed and initTime==0 -> SET.
- SET:
  - mode_btn: program <= program+1, wrapping 3->0.
  - start_btn with door_open=0 -> RUN.
  - start_btn with door_open=1: stay in SET, beep.
  - If mode_btn and start_btn arrive in the same cycle, start wins and program is unchanged.
- RUN:
  - armed and hadFinish=1 -> FINISH, with beep.
  - start_btn -> PAUSE.
  - door_open=1 -> PAUSE.
  - When hadFinish and start_btn are both valid in the same cycle, FINISH wins.
- PAUSE:
  - start_btn with door_open=0 -> RUN.
  - start_btn with door_open=1: stay in PAUSE, beep.
- ERROR:
  - start_btn with fault=0 -> SET; program retained.
  - start_btn with fault=1: ignored.
- FINISH: armed and finishTime==0 -> SHUTDOWN.
- Encoding 7 (illegal) -> SHUTDOWN on the next clk.
- beep is high for exactly one clk per qualifying event and is never stretched.

Optional Feature:
- Macro: WASH_DOOR_LOCK_EN.
- Defined:
  - Adds output port `door_lock` (1 bit), registered, reset 0.
  - door_lock=1 exactly while state==RUN.
  - door_open=1 in RUN -> ERROR with beep, instead of PAUSE.
- Undefined:
  - No `door_lock` port.
  - door_open in RUN -> PAUSE.

Test Plan:
1. Power-on sequence:
   - Stimulus: reset; power_btn; drive initTime=5 for 20 clk, then 0.
   - Response: state 0->1, stays 1 until initTime=0, then 2. data=0x?? fields 2,9,3,2,3,6,2,0. program=0.
2. Program select:
   - Stimulus: in SET, four mode_btn pulses, then one more.
   - Response: program 1,2,3,0,1. data fields follow the preset table one cycle after each pulse. Same-cycle mode+start -> RUN with program unchanged.
3. Run, pause, resume:
   - Stimulus: start_btn in SET with door closed -> RUN. Then door_open=1 -> PAUSE. Close door, start_btn.
   - Response: RUN restored. data unchanged throughout. Start with door open in PAUSE -> beep pulse, stays 5.
4. Stale-status masking:
   - Stimulus: enter RUN with hadFinish=1 held for the first 10 clk, then 0; later assert hadFinish=1.
   - Response: no FINISH during the first ARM_DELAY clk. FINISH with one beep after the later assertion. Then finishTime 0 (armed) -> SHUTDOWN.
5. Fault and power priority:
   - Stimulus: in RUN, fault=1 together with start_btn.
   - Response: ERROR, beep. start_btn while fault=1 is ignored. Drop fault, start_btn -> SET. power_btn together with fault in SET -> SHUTDOWN.
6. Reset mid-run:
   - Stimulus: rst_n=0 for 1 clk while in RUN with program=2.
   - Response: state=0, program=0, data=preset(0), beep=0. With WASH_DOOR_LOCK_EN: door_lock=0, and door_open in RUN -> ERROR.
